// File: rtl/extmem_arbiter_if.sv
// Bundle of requester-side and external-memory-side signals for extmem_arbiter.
// slave: the arbiter's view. master: the requesters plus the external memory.
interface extmem_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_write;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_grant;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    request_extmem;
  logic                    write_extmem;
  logic [ADDR_W-1:0]       addr_extmem;
  logic [DATA_W-1:0]       w_data;
  logic                    valid_extmem;
  logic [DATA_W-1:0]       data_extmem;
  logic                    busy;
  logic                    err_timeout;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, valid_extmem, data_extmem,
    output req_grant, rsp_valid, rsp_data, request_extmem, write_extmem,
           addr_extmem, w_data, busy, err_timeout
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, valid_extmem, data_extmem,
    input  req_grant, rsp_valid, rsp_data, request_extmem, write_extmem,
           addr_extmem, w_data, busy, err_timeout
  );
endinterface

// File: rtl/extmem_arbiter.sv
// Round-robin arbiter sharing one external-memory port between N_REQ requesters.
// One transaction in flight at a time; reads wait for valid_extmem (bounded by
// TIMEOUT), writes are a single request cycle. All outputs are registered.
module extmem_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  extmem_arbiter_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [N_REQ-1:0] ONE_HOT = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, RESP} state_t;
  typedef logic [IDX_W:0] cand_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [CNT_W-1:0] wait_cnt;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  // Round-robin pick: first pending requester scanning upward from last_grant+1, wrapping.
  always_comb begin
    cand_t cand;
    pick_found = 1'b0;
    pick_idx   = last_grant;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, last_grant} + cand_t'(k + 1);
      if (cand >= cand_t'(N_REQ)) cand = cand - cand_t'(N_REQ);
      if (!pick_found && bus.req_valid[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Transaction FSM; every output is a register written alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      last_grant         <= IDX_W'(N_REQ - 1);
      wait_cnt           <= '0;
      bus.req_grant      <= '0;
      bus.rsp_valid      <= '0;
      bus.rsp_data       <= '0;
      bus.request_extmem <= 1'b0;
      bus.write_extmem   <= 1'b0;
      bus.addr_extmem    <= '0;
      bus.w_data         <= '0;
      bus.busy           <= 1'b0;
      bus.err_timeout    <= 1'b0;
    end else begin
      bus.req_grant <= '0;
      bus.rsp_valid <= '0;
      case (state)
        IDLE: begin
          bus.request_extmem <= 1'b0;
          bus.write_extmem   <= 1'b0;
          if (pick_found) begin
            bus.req_grant   <= ONE_HOT << pick_idx;
            last_grant      <= pick_idx;
            bus.addr_extmem <= bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
            bus.w_data      <= bus.req_wdata[pick_idx*DATA_W +: DATA_W];
            wait_cnt        <= '0;
            bus.busy        <= 1'b1;
            state           <= bus.req_write[pick_idx] ? WRITE : READ_WAIT;
          end
        end
        WRITE: begin
          // The write request is visible during the following IDLE cycle.
          bus.request_extmem <= 1'b1;
          bus.write_extmem   <= 1'b1;
          bus.busy           <= 1'b0;
          state              <= IDLE;
        end
        READ_WAIT: begin
          if (!bus.request_extmem) begin
            // Grant cycle: raise the request; valid_extmem is not yet meaningful.
            bus.request_extmem <= 1'b1;
          end else if (bus.valid_extmem) begin
            bus.request_extmem <= 1'b0;
            bus.rsp_data       <= bus.data_extmem;
            bus.rsp_valid      <= ONE_HOT << last_grant;
            state              <= RESP;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            // Memory never answered: flag it and complete the read with zero data.
            bus.request_extmem <= 1'b0;
            bus.err_timeout    <= 1'b1;
            bus.rsp_data       <= '0;
            bus.rsp_valid      <= ONE_HOT << last_grant;
            state              <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_extmem_arbiter.sv
// Directed bench for extmem_arbiter: reset, single read/write timing,
// round-robin order, fairness, read timeout and reset during a read.
module tb_extmem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic rst;

  extmem_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  extmem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int gseq[8];

  // Memory model controls
  logic          mem_on   = 1'b0;
  int            mem_lat  = 2;
  logic [DW-1:0] mem_word = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Collect up to n grants (bounded), dropping each requester's req_valid when granted.
  task automatic collect_grants(input int n);
    int got;
    got = 0;
    for (int i = 0; i < 8; i++) gseq[i] = -1;
    for (int c = 0; c < 200 && got < n; c++) begin
      tick();
      for (int r = 0; r < N; r++) begin
        if (bus.req_grant[r] && got < 8) begin
          gseq[got] = r;
          got++;
          bus.req_valid[r] = 1'b0;
        end
      end
    end
  endtask

  // External memory: a read answered L cycles after request_extmem rises.
  initial begin
    int cnt;
    cnt = 0;
    bus.valid_extmem = 1'b0;
    bus.data_extmem  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.request_extmem && !bus.write_extmem) begin
        cnt++;
        if (mem_on && cnt == mem_lat + 1) begin
          bus.valid_extmem = 1'b1;
          bus.data_extmem  = mem_word;
        end else begin
          bus.valid_extmem = 1'b0;
        end
      end else begin
        cnt = 0;
        bus.valid_extmem = 1'b0;
      end
    end
  end

  initial begin
    logic [N-1:0] seen;
    logic [N-1:0] rv;
    logic [DW-1:0] rd;

    rst = 1'b0;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    tick();
    tick();
    // Reset state
    check("rst_request", bus.request_extmem, 0);
    check("rst_busy",    bus.busy, 0);
    check("rst_grant",   bus.req_grant, 0);
    check("rst_err",     bus.err_timeout, 0);
    rst = 1'b1;

    // Idle: no grant without req_valid
    seen = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= bus.req_grant;
    end
    check("idle_no_grant", seen, 0);
    check("idle_busy", bus.busy, 0);

    // Single read: req 0, addr 0x0020_0004, L=2, data 0xDEADBEEF
    mem_on   = 1'b1;
    mem_lat  = 2;
    mem_word = 32'hDEAD_BEEF;
    bus.req_addr[0 +: AW] = 32'h0020_0004;
    bus.req_write[0] = 1'b0;
    bus.req_valid[0] = 1'b1;
    tick();                               // T
    check("rd_grant_T", bus.req_grant, 4'b0001);
    check("rd_req_T", bus.request_extmem, 0);
    check("rd_busy_T", bus.busy, 1);
    bus.req_valid[0] = 1'b0;
    tick();                               // T+1
    check("rd_req_T1", bus.request_extmem, 1);
    check("rd_addr_T1", bus.addr_extmem, 32'h0020_0004);
    check("rd_wr_T1", bus.write_extmem, 0);
    check("rd_grant_T1", bus.req_grant, 0);
    tick();                               // T+2
    check("rd_req_T2", bus.request_extmem, 1);
    tick();                               // T+3
    check("rd_req_T3", bus.request_extmem, 1);
    check("rd_rsp_T3", bus.rsp_valid, 0);
    tick();                               // T+4
    check("rd_req_T4", bus.request_extmem, 0);
    check("rd_rsp_T4", bus.rsp_valid, 4'b0001);
    check("rd_data_T4", bus.rsp_data, 32'hDEAD_BEEF);
    tick();                               // T+5
    check("rd_rsp_T5", bus.rsp_valid, 0);
    check("rd_data_hold", bus.rsp_data, 32'hDEAD_BEEF);
    check("rd_busy_T5", bus.busy, 0);

    // Single write: req 3 writes 0x1234 to 0x0040_0010
    bus.req_addr[3*AW +: AW]  = 32'h0040_0010;
    bus.req_wdata[3*DW +: DW] = 32'h0000_1234;
    bus.req_write[3] = 1'b1;
    bus.req_valid[3] = 1'b1;
    tick();                               // T
    check("wr_grant_T", bus.req_grant, 4'b1000);
    check("wr_req_T", bus.request_extmem, 0);
    bus.req_valid[3] = 1'b0;
    bus.req_write[3] = 1'b0;
    tick();                               // T+1
    check("wr_req_T1", bus.request_extmem, 1);
    check("wr_we_T1", bus.write_extmem, 1);
    check("wr_addr_T1", bus.addr_extmem, 32'h0040_0010);
    check("wr_data_T1", bus.w_data, 32'h0000_1234);
    tick();                               // T+2
    check("wr_req_T2", bus.request_extmem, 0);
    check("wr_we_T2", bus.write_extmem, 0);

    // Round robin: all four read together, twice
    mem_lat  = 1;
    mem_word = 32'hCAFE_0000;
    for (int r = 0; r < N; r++) bus.req_addr[r*AW +: AW] = 32'h1000 + 32'(r * 4);
    bus.req_write = '0;
    bus.req_valid = '1;
    collect_grants(4);
    check("rr1_0", gseq[0], 0);
    check("rr1_1", gseq[1], 1);
    check("rr1_2", gseq[2], 2);
    check("rr1_3", gseq[3], 3);
    bus.req_valid = '1;
    collect_grants(4);
    check("rr2_0", gseq[0], 0);
    check("rr2_1", gseq[1], 1);
    check("rr2_2", gseq[2], 2);
    check("rr2_3", gseq[3], 3);
    for (int i = 0; i < 6; i++) tick();

    // Fairness: after a grant to 2, pending 1 and 3 -> 3 first
    bus.req_valid[2] = 1'b1;
    collect_grants(1);
    check("fair_g2", gseq[0], 2);
    for (int i = 0; i < 6; i++) tick();
    bus.req_valid[1] = 1'b1;
    bus.req_valid[3] = 1'b1;
    collect_grants(2);
    check("fair_first", gseq[0], 3);
    check("fair_second", gseq[1], 1);
    for (int i = 0; i < 6; i++) tick();

    // Timeout: read with no valid_extmem, TIMEOUT=16
    mem_on = 1'b0;
    bus.req_valid[0] = 1'b1;
    tick();                               // T
    check("to_grant", bus.req_grant, 4'b0001);
    bus.req_valid[0] = 1'b0;
    for (int i = 0; i < 16; i++) tick();  // T+16
    check("to_req_T16", bus.request_extmem, 1);
    check("to_err_T16", bus.err_timeout, 0);
    tick();                               // T+17
    check("to_err_T17", bus.err_timeout, 1);
    check("to_rsp_T17", bus.rsp_valid, 4'b0001);
    check("to_data_T17", bus.rsp_data, 0);
    check("to_req_T17", bus.request_extmem, 0);

    // Next request still served after a timeout
    mem_on   = 1'b1;
    mem_lat  = 1;
    mem_word = 32'h5555_AAAA;
    bus.req_valid[2] = 1'b1;
    collect_grants(1);
    check("post_to_grant", gseq[0], 2);
    rv = '0;
    rd = '0;
    for (int i = 0; i < 10 && rv == '0; i++) begin
      tick();
      rv = bus.rsp_valid;
      rd = bus.rsp_data;
    end
    check("post_to_rsp", rv, 4'b0100);
    check("post_to_data", rd, 32'h5555_AAAA);
    check("post_to_err_sticky", bus.err_timeout, 1);
    for (int i = 0; i < 4; i++) tick();

    // Reset mid-read: outputs clear at once, nothing afterwards
    mem_on = 1'b0;
    bus.req_valid[1] = 1'b1;
    collect_grants(1);
    check("mid_grant", gseq[0], 1);
    tick();
    tick();
    check("mid_req_before", bus.request_extmem, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_req",  bus.request_extmem, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_err",  bus.err_timeout, 0);
    check("mid_rst_addr", bus.addr_extmem, 0);
    check("mid_rst_data", bus.rsp_data, 0);
    tick();
    rst = 1'b1;
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= bus.req_grant | bus.rsp_valid;
    end
    check("mid_after_quiet", seen, 0);

    // last_grant back at N-1 after reset: 0 wins over 1
    mem_on = 1'b1;
    bus.req_valid[0] = 1'b1;
    bus.req_valid[1] = 1'b1;
    collect_grants(2);
    check("rst_rr_first", gseq[0], 0);
    check("rst_rr_second", gseq[1], 1);
    for (int i = 0; i < 6; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
